mem_arbiter: RTL and testbench

Shares one line-wide backing-memory port between the instruction cache and the data cache. Each cache presents a request/valid handshake toward memory. The arbiter grants one requester at a time using round-robin and forwards the command to memory as registered signals. It routes the memory's completion and read line back to the granted requester. It sits at cpu level, between the IC/DC miss and write-back ports and a single external memory.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of IC, DC and backing-memory signals seen by the line arbiter.
// MEM_ARB_STATS_EN adds the grant/wait counter outputs.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64
);
  logic                 i_readM;
  logic                 i_writeM;
  logic [WORD_SIZE-1:0] i_address;
  logic [LINE_SIZE-1:0] i_wdata;
  logic [LINE_SIZE-1:0] i_rdata;
  logic                 i_valid;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [LINE_SIZE-1:0] d_wdata;
  logic [LINE_SIZE-1:0] d_rdata;
  logic                 d_valid;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [LINE_SIZE-1:0] m_wdata;
  logic [LINE_SIZE-1:0] m_rdata;
  logic                 m_valid;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]          i_grant_cnt;
  logic [15:0]          d_grant_cnt;
  logic [15:0]          wait_cnt;
`endif

  modport master (
    input  i_readM, i_writeM, i_address, i_wdata,
    output i_rdata, i_valid,
    input  d_readM, d_writeM, d_address, d_wdata,
    output d_rdata, d_valid,
    output m_readM, m_writeM, m_address, m_wdata,
`ifdef MEM_ARB_STATS_EN
    output i_grant_cnt, d_grant_cnt, wait_cnt,
`endif
    input  m_rdata, m_valid
  );

  modport slave (
    output i_readM, i_writeM, i_address, i_wdata,
    input  i_rdata, i_valid,
    output d_readM, d_writeM, d_address, d_wdata,
    input  d_rdata, d_valid,
    input  m_readM, m_writeM, m_address, m_wdata,
`ifdef MEM_ARB_STATS_EN
    input  i_grant_cnt, d_grant_cnt, wait_cnt,
`endif
    output m_rdata, m_valid
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin IC/DC arbiter onto one line-wide memory port, registered command.
// Optional MEM_ARB_STATS_EN adds saturating grant and wait counters.
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64
) (
  input  logic          Clk,
  input  logic          Reset_N,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RECOVER
  } state_e;

  state_e               state_q, state_d;
  logic                 last_d_q, last_d_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
  logic [LINE_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic                 req_i, req_d;
  logic                 gnt_i, gnt_d;

  // last_d_q=1 means D was served last, so I wins the next tie
  always_comb begin
    req_i     = bus.i_readM | bus.i_writeM;
    req_d     = bus.d_readM | bus.d_writeM;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        gnt_d     = req_d & (~req_i | ~last_d_q);
        gnt_i     = req_i & ~gnt_d;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
        unique case (1'b1)
          gnt_d: begin
            state_d   = GRANT_D;
            last_d_d  = 1'b1;
            m_write_d = bus.d_writeM;
            m_read_d  = bus.d_readM & ~bus.d_writeM;
            m_addr_d  = bus.d_address;
            m_wdata_d = bus.d_wdata;
          end
          gnt_i: begin
            state_d   = GRANT_I;
            last_d_d  = 1'b0;
            m_write_d = bus.i_writeM;
            m_read_d  = bus.i_readM & ~bus.i_writeM;
            m_addr_d  = bus.i_address;
            m_wdata_d = bus.i_wdata;
          end
          default: ;
        endcase
      end
      GRANT_I, GRANT_D: begin
        if (bus.m_valid) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign bus.m_readM   = m_read_q;
  assign bus.m_writeM  = m_write_q;
  assign bus.m_address = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;

  assign bus.i_valid = (state_q == GRANT_I) & bus.m_valid;
  assign bus.d_valid = (state_q == GRANT_D) & bus.m_valid;
  assign bus.i_rdata = (state_q == GRANT_I) ? bus.m_rdata : '0;
  assign bus.d_rdata = (state_q == GRANT_D) ? bus.m_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] i_cnt_q, i_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;
  logic [15:0] w_cnt_q, w_cnt_d;
  logic        waiting;

  always_comb begin
    waiting = (req_i & ~gnt_i & (state_q != GRANT_I))
            | (req_d & ~gnt_d & (state_q != GRANT_D));
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    w_cnt_d = w_cnt_q;
    if (gnt_i && i_cnt_q != 16'hFFFF) i_cnt_d = i_cnt_q + 16'd1;
    if (gnt_d && d_cnt_q != 16'hFFFF) d_cnt_d = d_cnt_q + 16'd1;
    if (waiting && w_cnt_q != 16'hFFFF) w_cnt_d = w_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      w_cnt_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      w_cnt_q <= w_cnt_d;
    end
  end

  assign bus.i_grant_cnt = i_cnt_q;
  assign bus.d_grant_cnt = d_cnt_q;
  assign bus.wait_cnt    = w_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random run.
// Counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;
  localparam int WS = 16;
  localparam int LS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_SIZE(WS), .LINE_SIZE(LS)) bus ();

  mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS)) dut (
    .Clk    (clk),
    .Reset_N(rst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          port;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [63:0] wd;
    logic [63:0] rdat;
    int          dly;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;
  vec_t vt[5];

  bit          pend[2];
  bit          hold_off[2];
  logic        rdq[2];
  logic        wrq[2];
  logic [15:0] aq[2];
  logic [63:0] wq[2];
  int          tq[2];
  bit          outst, win, last_win, ci, cd, mv;
  int          done_c, cnt, w, k;
  logic [63:0] rd_v;
  logic [15:0] ca[2];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [63:0] wd);
    if (p) begin
      bus.d_readM = rd; bus.d_writeM = wr;
      bus.d_address = a; bus.d_wdata = wd;
    end else begin
      bus.i_readM = rd; bus.i_writeM = wr;
      bus.i_address = a; bus.i_wdata = wd;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
    bus.m_valid = 1'b0;
    bus.m_rdata = 64'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_cmd(input string nm, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [63:0] wd);
    chk(nm, {bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata},
        {rd, wr, a, wd});
  endtask

  // Called with the command visible; returns in the cycle after m_valid.
  task automatic serve(input bit p, input int dly, input logic [63:0] rdat);
    repeat (dly - 1) tick();
    tick();
    bus.m_valid = 1'b1;
    bus.m_rdata = rdat;
    #1;
    chk("x_valid", {bus.i_valid, bus.d_valid}, p ? 2'b01 : 2'b10);
    chk("x_rdata", p ? bus.d_rdata : bus.i_rdata, rdat);
    chk("other_rdata", p ? bus.i_rdata : bus.d_rdata, 64'h0);
    tick();
    bus.m_valid = 1'b0;
    bus.m_rdata = 64'h0;
    set_req(p, 1'b0, 1'b0, 16'h0, 64'h0);
    #1;
    chk("cmd_clear", {bus.m_readM, bus.m_writeM}, 2'b00);
    chk("valid_after", {bus.i_valid, bus.d_valid}, 2'b00);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 64'h0,
              64'h0123_4567_89AB_CDEF, 3, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 16'h0300, 64'h1111_2222_3333_4444,
              64'h5555_0000_5555_0000, 1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0A0A, 64'hCAFE_F00D_1234_5678,
              64'h0, 2, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 64'h8000_0000_0000_0001,
              64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 16'h0000, 64'hA5A5_A5A5_5A5A_5A5A,
              64'h0000_0000_0000_0001, 2, 1'b0, 1'b1};

    do_reset();
    chk_cmd("reset_cmd", 1'b0, 1'b0, 16'h0, 64'h0);
    chk("reset_valid", {bus.i_valid, bus.d_valid}, 2'b00);

    for (int i = 0; i < 5; i++) begin
      set_req(vt[i].port, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd);
      tick();
      chk_cmd("vec_cmd", vt[i].exp_rd, vt[i].exp_wr, vt[i].a, vt[i].wd);
      chk("vec_pre_valid", {bus.i_valid, bus.d_valid}, 2'b00);
      serve(vt[i].port, vt[i].dly, vt[i].rdat);
      tick();
      chk("vec_idle_cmd", {bus.m_readM, bus.m_writeM}, 2'b00);
    end

    // first tie after reset goes to D, then I after RECOVER + IDLE
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 16'h0010, 64'h0);
    set_req(1'b1, 1'b0, 1'b1, 16'h0200, 64'hDEAD_BEEF_0000_FFFF);
    tick();
    chk_cmd("tie_d_first", 1'b0, 1'b1, 16'h0200, 64'hDEAD_BEEF_0000_FFFF);
    serve(1'b1, 2, 64'h0);
    tick();
    chk("tie_idle_gap", {bus.m_readM, bus.m_writeM}, 2'b00);
    tick();
    chk_cmd("tie_i_second", 1'b1, 1'b0, 16'h0010, 64'h0);
    serve(1'b0, 1, 64'h0123);
    tick();

    // continuous contention alternates D, I, D, I, D, I
    do_reset();
    ca[0] = 16'h1000;
    ca[1] = 16'h2000;
    set_req(1'b0, 1'b1, 1'b0, ca[0], 64'h0);
    set_req(1'b1, 1'b1, 1'b0, ca[1], 64'h0);
    for (int n = 0; n < 6; n++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!(bus.m_readM | bus.m_writeM) && w < 8);
      chk("rr_timeout", w < 8, 1'b1);
      chk("rr_order", bus.m_address, ca[(n % 2 == 0) ? 1 : 0]);
      serve((n % 2 == 0), 2, {32'h0, n});
      ca[(n % 2 == 0) ? 1 : 0] += 16'h1;
      set_req((n % 2 == 0), 1'b1, 1'b0, ca[(n % 2 == 0) ? 1 : 0], 64'h0);
    end
`ifdef MEM_ARB_STATS_EN
    chk("i_grant_cnt", bus.i_grant_cnt, 16'd3);
    chk("d_grant_cnt", bus.d_grant_cnt, 16'd3);
    chk("wait_cnt_pos", bus.wait_cnt != 16'd0, 1'b1);
`endif
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
    tick();
    tick();

    // stray m_valid in IDLE and RECOVER must be ignored
    bus.m_valid = 1'b1;
    bus.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("spur_idle_valid", {bus.i_valid, bus.d_valid}, 2'b00);
    chk("spur_idle_rdata", {bus.i_rdata, bus.d_rdata}, 128'h0);
    tick();
    bus.m_valid = 1'b0;
    chk("spur_idle_cmd", {bus.m_readM, bus.m_writeM}, 2'b00);
    set_req(1'b0, 1'b1, 1'b0, 16'h0040, 64'h0);
    tick();
    chk_cmd("spur_after_idle", 1'b1, 1'b0, 16'h0040, 64'h0);
    serve(1'b0, 2, 64'h77);
    bus.m_valid = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 16'h0444, 64'h9);
    #1;
    chk("spur_rec_valid", {bus.i_valid, bus.d_valid}, 2'b00);
    tick();
    bus.m_valid = 1'b0;
    chk("spur_rec_gap", {bus.m_readM, bus.m_writeM}, 2'b00);
    tick();
    chk_cmd("spur_after_rec", 1'b1, 1'b0, 16'h0444, 64'h9);
    serve(1'b1, 1, 64'h88);
    tick();

    // async reset in GRANT_D aborts without a clock edge
    set_req(1'b1, 1'b0, 1'b1, 16'h0BEE, 64'h42);
    tick();
    chk_cmd("pre_reset_cmd", 1'b0, 1'b1, 16'h0BEE, 64'h42);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cmd("async_reset_cmd", 1'b0, 1'b0, 16'h0, 64'h0);
    bus.m_valid = 1'b1;
    #1;
    chk("async_reset_valid", {bus.i_valid, bus.d_valid}, 2'b00);
    bus.m_valid = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    set_req(1'b0, 1'b1, 1'b0, 16'h0123, 64'h0);
    tick();
    chk_cmd("post_reset_cmd", 1'b1, 1'b0, 16'h0123, 64'h0);
    serve(1'b0, 3, 64'hFACE);

    // random traffic against a transaction-level model
    do_reset();
    last_win = 1'b1;
    done_c = -100;
    outst = 1'b0;
    win = 1'b0;
    cnt = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      hold_off[p] = 1'b0;
      tq[p] = 0;
    end
    last_win = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!outst) begin
        ci = pend[0] && tq[0] <= c - 1;
        cd = pend[1] && tq[1] <= c - 1;
        if ((ci || cd) && c >= done_c + 3) begin
          win = (ci && cd) ? ~last_win : cd;
          last_win = win;
          outst = 1'b1;
          cnt = $urandom_range(1, 5);
        end
      end
      if (outst)
        chk_cmd("rand_cmd", rdq[win] & ~wrq[win], wrq[win], aq[win], wq[win]);
      else
        chk("rand_nocmd", {bus.m_readM, bus.m_writeM}, 2'b00);

      mv = 1'b0;
      if (outst) begin
        cnt--;
        mv = (cnt == 0);
      end else begin
        mv = ($urandom_range(0, 9) == 0);
      end
      rd_v = {$urandom, $urandom};
      bus.m_valid = mv;
      bus.m_rdata = rd_v;

      for (int p = 0; p < 2; p++) begin
        if (hold_off[p]) begin
          hold_off[p] = 1'b0;
          set_req(p[0], 1'b0, 1'b0, 16'h0, 64'h0);
        end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          tq[p] = c;
          aq[p] = 16'($urandom);
          wq[p] = {$urandom, $urandom};
          k = $urandom_range(0, 9);
          rdq[p] = (k < 5) || (k == 9);
          wrq[p] = (k >= 5);
          set_req(p[0], rdq[p], wrq[p], aq[p], wq[p]);
        end
      end

      #1;
      chk("rand_valid", {bus.i_valid, bus.d_valid},
          (outst && mv) ? (win ? 2'b01 : 2'b10) : 2'b00);
      chk("rand_rdata", {bus.i_rdata, bus.d_rdata},
          outst ? (win ? {64'h0, rd_v} : {rd_v, 64'h0}) : 128'h0);
      if (outst && mv) begin
        outst = 1'b0;
        done_c = c;
        pend[win] = 1'b0;
        hold_off[win] = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
